// File: rtl/packet_parser_n6_if.sv
// Packet word stream plus parsed-header results.
//   bus               : 32-bit packet word, first byte in [31:24]
//   start_of_packet_i : marks word 0 of a packet
//   phs_o             : parsed-header summary (flags, IHL, TCP offset, payload offset)
//   pay_last_word     : index of the last bus word holding packet bytes
// master = packet source / result consumer, slave = parser.
interface packet_parser_n6_if;
  localparam int unsigned W_WORD = 32;

  logic [W_WORD-1:0] bus;
  logic              start_of_packet_i;
  logic [W_WORD-1:0] phs_o;
  logic [W_WORD-1:0] pay_last_word;

  modport master (
    output bus,
    output start_of_packet_i,
    input  phs_o,
    input  pay_last_word
  );

  modport slave (
    input  bus,
    input  start_of_packet_i,
    output phs_o,
    output pay_last_word
  );
endinterface

// File: rtl/packet_parser_n6.sv
// Ethernet II / IPv4 / UDP|TCP header parser, one 32-bit word per cycle.
//   CLK   : rising-edge clock
//   reset : synchronous active-high reset
//   pif   : slave side of packet_parser_n6_if (bus, start_of_packet_i in;
//           phs_o, pay_last_word out, both registered)
// phs_o layout: [7:0] flags {rsvd,DONE,ERROR,UNSUP,TCP,UDP,IPV4,ETH},
//               [11:8] IHL, [15:12] TCP data offset, [31:16] payload offset.
module packet_parser_n6 (
  input  logic               CLK,
  input  logic               reset,
  packet_parser_n6_if.slave  pif
);
  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_CNT  = 16;

  localparam int unsigned F_ETH   = 0;
  localparam int unsigned F_IPV4  = 1;
  localparam int unsigned F_UDP   = 2;
  localparam int unsigned F_TCP   = 3;
  localparam int unsigned F_UNSUP = 4;
  localparam int unsigned F_ERR   = 5;
  localparam int unsigned F_DONE  = 6;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;
  localparam logic [7:0]  PROTO_TCP  = 8'd6;
  localparam logic [15:0] ETH_HDR    = 16'd14;
  localparam logic [15:0] UDP_HDR    = 16'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ETH,
    S_IPV4,
    S_L4,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;
  logic [W_CNT-1:0]    idx;
  logic [W_WORD-1:0]   phs_q, phs_d;
  logic [W_WORD-1:0]   plw_q, plw_d;
  logic [3:0]          ihl_q;
  logic [15:0]         l4_start;
  logic [15:0]         tot_len;

  // IHL already latched into phs at word 3 is reused for all later offsets.
  assign ihl_q    = phs_q[11:8];
  assign l4_start = ETH_HDR + 16'({ihl_q, 2'b00});
  assign tot_len  = pif.bus[31:16];

  // State, word counter and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phs_q   <= '0;
      plw_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phs_q   <= phs_d;
      plw_q   <= plw_d;
    end
  end

  // Next-state and parsed-field update for the word currently on the bus.
  always_comb begin
    state_d = state_q;
    phs_d   = phs_q;
    plw_d   = plw_q;

    // idx is the index of the word on the bus: 0 on start-of-packet.
    idx   = pif.start_of_packet_i ? '0 : cnt_q;
    cnt_d = (idx == {W_CNT{1'b1}}) ? idx : idx + W_CNT'(1);

    if (pif.start_of_packet_i) begin
      // Word 0 only holds MAC bytes, so a restart just clears results.
      phs_d   = '0;
      plw_d   = '0;
      state_d = S_ETH;
    end else begin
      unique case (state_q)
        S_ETH: begin
          if (idx == W_CNT'(3)) begin
            phs_d[F_ETH] = 1'b1;
            if (pif.bus[31:16] != ETYPE_IPV4) begin
              phs_d[F_UNSUP] = 1'b1;
              phs_d[F_DONE]  = 1'b1;
              phs_d[31:16]   = ETH_HDR;
              state_d        = S_DONE;
            end else if ((pif.bus[15:12] != 4'd4) || (pif.bus[11:8] < 4'd5)) begin
              phs_d[F_ERR]  = 1'b1;
              phs_d[F_DONE] = 1'b1;
              state_d       = S_DONE;
            end else begin
              phs_d[11:8] = pif.bus[11:8];
              state_d     = S_IPV4;
            end
          end
        end

        S_IPV4: begin
          if (idx == W_CNT'(4)) begin
            plw_d = (W_WORD'(ETH_HDR) + W_WORD'(tot_len) - W_WORD'(1)) >> 2;
            if (tot_len < 16'({ihl_q, 2'b00})) begin
              phs_d[F_ERR]  = 1'b1;
              phs_d[F_DONE] = 1'b1;
              state_d       = S_DONE;
            end
          end else if (idx == W_CNT'(5)) begin
            phs_d[F_IPV4] = 1'b1;
            if (pif.bus[7:0] == PROTO_UDP) begin
              phs_d[F_UDP]  = 1'b1;
              phs_d[F_DONE] = 1'b1;
              phs_d[31:16]  = l4_start + UDP_HDR;
              state_d       = S_DONE;
            end else if (pif.bus[7:0] == PROTO_TCP) begin
              phs_d[F_TCP] = 1'b1;
              state_d      = S_L4;
            end else begin
              phs_d[F_UNSUP] = 1'b1;
              phs_d[F_DONE]  = 1'b1;
              phs_d[31:16]   = l4_start;
              state_d        = S_DONE;
            end
          end
        end

        S_L4: begin
          // TCP data-offset byte always lands in bits [15:12] of word 6+IHL.
          if (idx == W_CNT'(6) + W_CNT'(ihl_q)) begin
            phs_d[F_DONE] = 1'b1;
            state_d       = S_DONE;
            if (pif.bus[15:12] < 4'd5) begin
              phs_d[F_ERR] = 1'b1;
            end else begin
              phs_d[15:12] = pif.bus[15:12];
              phs_d[31:16] = l4_start + 16'({pif.bus[15:12], 2'b00});
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign pif.phs_o         = phs_q;
  assign pif.pay_last_word = plw_q;
endmodule

// File: tb/tb_packet_parser_n6.sv
// Directed bench for packet_parser_n6: builds frames byte by byte, streams
// them one word per cycle and checks phs_o / pay_last_word at key words.
module tb_packet_parser_n6;
  logic CLK;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [31:0] wq[$];

  packet_parser_n6_if pif ();

  packet_parser_n6 dut (
    .CLK   (CLK),
    .reset (reset),
    .pif   (pif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word at the falling edge; return just after the next rising edge.
  task automatic send_word(input logic [31:0] w, input logic s, input logic r);
    @(negedge CLK);
    pif.bus               = w;
    pif.start_of_packet_i = s;
    reset                 = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_range(input int a, input int b);
    for (int i = a; i <= b; i++) send_word(wq[i], (i == 0), 1'b0);
  endtask

  // Build a frame into wq. Non-IPv4 frames get a few filler bytes.
  task automatic build(input logic [15:0] etype, input logic [3:0] ver,
                       input logic [3:0] ihl, input logic [15:0] tlen,
                       input logic [7:0] proto, input logic [3:0] toff,
                       input int dlen);
    logic [7:0] bq[$];
    logic [15:0] ulen;
    bq = {};
    for (int i = 0; i < 12; i++) bq.push_back(8'(8'h10 + i));
    bq.push_back(etype[15:8]);
    bq.push_back(etype[7:0]);
    if (etype == 16'h0800) begin
      bq.push_back({ver, ihl});
      bq.push_back(8'h00);
      bq.push_back(tlen[15:8]);
      bq.push_back(tlen[7:0]);
      bq.push_back(8'h12); bq.push_back(8'h34);
      bq.push_back(8'h40); bq.push_back(8'h00);
      bq.push_back(8'h40); bq.push_back(proto);
      bq.push_back(8'h00); bq.push_back(8'h00);
      bq.push_back(8'hC0); bq.push_back(8'hA8); bq.push_back(8'h00); bq.push_back(8'h01);
      bq.push_back(8'hC0); bq.push_back(8'hA8); bq.push_back(8'h00); bq.push_back(8'h02);
      for (int i = 0; i < (int'(ihl) - 5) * 4; i++) bq.push_back(8'h01);
      if (proto == 8'd17) begin
        ulen = 16'(8 + dlen);
        bq.push_back(8'h04); bq.push_back(8'hD2);
        bq.push_back(8'h16); bq.push_back(8'h2E);
        bq.push_back(ulen[15:8]); bq.push_back(ulen[7:0]);
        bq.push_back(8'h00); bq.push_back(8'h00);
      end else if (proto == 8'd6) begin
        for (int i = 0; i < 4 * int'(toff); i++)
          bq.push_back((i == 12) ? {toff, 4'h0} : 8'(8'h80 + i));
      end
    end else begin
      for (int i = 0; i < 10; i++) bq.push_back(8'(8'h60 + i));
    end
    for (int i = 0; i < dlen; i++) bq.push_back(8'(8'hD0 + i));
    while ((bq.size() % 4) != 0) bq.push_back(8'h00);
    wq = {};
    for (int i = 0; i < bq.size(); i += 4)
      wq.push_back({bq[i], bq[i+1], bq[i+2], bq[i+3]});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pif.bus = '0;
    pif.start_of_packet_i = 1'b0;

    // Reset state
    send_word(32'h0, 1'b0, 1'b1);
    send_word(32'h0, 1'b0, 1'b1);
    chk("rst_phs", pif.phs_o, 32'h0);
    chk("rst_plw", pif.pay_last_word, 32'h0);

    // UDP, IHL=5, 12 data bytes, total_len=40
    build(16'h0800, 4'd4, 4'd5, 16'd40, 8'd17, 4'd0, 12);
    send_range(0, 3);
    chk("udp_w3_phs", pif.phs_o, 32'h0000_0501);
    send_range(4, 4);
    chk("udp_w4_plw", pif.pay_last_word, 32'd13);
    send_range(5, 5);
    chk("udp_w5_phs", pif.phs_o, 32'h002A_0547);
    send_range(6, 13);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_word(32'h0800_45FF, 1'b0, 1'b0);
    chk("udp_hold_phs", pif.phs_o, 32'h002A_0547);
    chk("udp_hold_plw", pif.pay_last_word, 32'd13);

    // TCP, IHL=7, offset=8, 15 data bytes, total_len=75
    build(16'h0800, 4'd4, 4'd7, 16'd75, 8'd6, 4'd8, 15);
    send_range(0, 0);
    chk("tcp_w0_phs", pif.phs_o, 32'h0);
    chk("tcp_w0_plw", pif.pay_last_word, 32'h0);
    send_range(1, 5);
    chk("tcp_w5_phs", pif.phs_o, 32'h0000_070B);
    send_range(6, 12);
    chk("tcp_w12_phs", pif.phs_o, 32'h0000_070B);
    chk("tcp_w12_plw", pif.pay_last_word, 32'd22);
    send_range(13, 13);
    chk("tcp_w13_phs", pif.phs_o, 32'h004A_874B);
    send_range(14, 22);
    chk("tcp_end_phs", pif.phs_o, 32'h004A_874B);

    // Non-IPv4 EtherType
    build(16'h86DD, 4'd0, 4'd0, 16'd0, 8'd0, 4'd0, 0);
    send_range(0, 3);
    chk("v6_phs", pif.phs_o, 32'h000E_0051);
    chk("v6_plw", pif.pay_last_word, 32'h0);

    // Restart at word 2 of a UDP packet, then a full TCP (IHL=5, off=5, 4 data bytes)
    build(16'h0800, 4'd4, 4'd5, 16'd40, 8'd17, 4'd0, 12);
    send_range(0, 1);
    build(16'h0800, 4'd4, 4'd5, 16'd44, 8'd6, 4'd5, 4);
    send_range(0, 0);
    chk("rs2_clr_phs", pif.phs_o, 32'h0);
    send_range(1, 5);
    chk("rs2_w5_phs", pif.phs_o, 32'h0000_050B);
    send_range(6, 14);
    chk("rs2_phs", pif.phs_o, 32'h0036_554B);
    chk("rs2_plw", pif.pay_last_word, 32'd14);

    // Restart after word 4 of a UDP packet clears non-zero outputs
    build(16'h0800, 4'd4, 4'd5, 16'd40, 8'd17, 4'd0, 12);
    send_range(0, 4);
    chk("rs4_pre_plw", pif.pay_last_word, 32'd13);
    build(16'h0800, 4'd4, 4'd5, 16'd44, 8'd6, 4'd5, 4);
    send_range(0, 0);
    chk("rs4_clr_phs", pif.phs_o, 32'h0);
    chk("rs4_clr_plw", pif.pay_last_word, 32'h0);
    send_range(1, 14);
    chk("rs4_phs", pif.phs_o, 32'h0036_554B);

    // Reset during word 4: parse abandoned until the next start-of-packet
    build(16'h0800, 4'd4, 4'd5, 16'd40, 8'd17, 4'd0, 12);
    send_range(0, 3);
    send_word(wq[4], 1'b0, 1'b1);
    chk("rstm_phs", pif.phs_o, 32'h0);
    chk("rstm_plw", pif.pay_last_word, 32'h0);
    for (int i = 5; i <= 13; i++) send_word(wq[i], 1'b0, 1'b0);
    chk("rstm_end_phs", pif.phs_o, 32'h0);
    chk("rstm_end_plw", pif.pay_last_word, 32'h0);

    // IHL=4 is an error
    build(16'h0800, 4'd4, 4'd4, 16'd40, 8'd17, 4'd0, 12);
    send_range(0, 3);
    chk("ihl4_flags", 32'(pif.phs_o[7:0]), 32'h61);

    // total_len shorter than the IPv4 header
    build(16'h0800, 4'd4, 4'd6, 16'd20, 8'd17, 4'd0, 0);
    send_range(0, 4);
    chk("tlen_flags", 32'(pif.phs_o[7:0]), 32'h61);
    chk("tlen_plw", pif.pay_last_word, 32'd8);

    // Unsupported IP protocol (ICMP)
    build(16'h0800, 4'd4, 4'd5, 16'd28, 8'd1, 4'd0, 8);
    send_range(0, 5);
    chk("icmp_phs", pif.phs_o, 32'h0022_0553);
    chk("icmp_plw", pif.pay_last_word, 32'd10);

    // TCP data offset below 5
    build(16'h0800, 4'd4, 4'd5, 16'd40, 8'd6, 4'd4, 0);
    send_range(0, 11);
    chk("tcpoff_flags", 32'(pif.phs_o[7:0]), 32'h6B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
